// File: rtl/th_response_checker_pkg.sv
// th_response_checker_pkg: shared harness constants, descriptor layout and FSM encodings.
// Rev 1.0
`default_nettype none

package th_response_checker_pkg;

  localparam int unsigned DESC_FIELD_W = 32;
  localparam int unsigned DESC_ENTRY_W = 3 * DESC_FIELD_W;
  localparam int unsigned OPC_READ     = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  typedef struct packed {
    logic [DESC_FIELD_W-1:0] addr;
    logic [DESC_FIELD_W-1:0] base;
    logic [DESC_FIELD_W-1:0] count;
  } desc_t;

  function automatic int unsigned desc_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/th_desc_fifo.sv
// th_desc_fifo: pending read-descriptor FIFO, valid/ready on both sides.
// Rev 1.0
`default_nettype none

module th_desc_fifo
  import th_response_checker_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = DESC_ENTRY_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_valid_i,
  input  logic [Width-1:0] push_data_i,
  output logic             push_ready_o,
  input  logic             pop_ready_i,
  output logic             pop_valid_o,
  output logic [Width-1:0] pop_data_o
);

  localparam int unsigned PtrW = desc_ptr_w(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             full, empty, push_ok, pop_ok;

  // Fullness comes from the registered count, so a same-cycle pop never opens a slot.
  assign full         = (count_q == (PtrW+1)'(Depth));
  assign empty        = (count_q == '0);
  assign push_ok      = push_valid_i && !full;
  assign pop_ok       = pop_ready_i && !empty;
  assign push_ready_o = !full;
  assign pop_valid_o  = !empty;
  assign pop_data_o   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/th_response_checker.sv
// th_response_checker: checks received response words against queued read descriptors.
// Rev 1.0
`default_nettype none

module th_response_checker
  import th_response_checker_pkg::*;
#(
  parameter int unsigned DBaseWidth    = 64,
  parameter int unsigned DescDepth     = 8,
  parameter int unsigned CntWidth      = 32,
  parameter int unsigned TimeoutCycles = 1_000_000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           desc_addr_i,
  input  logic [31:0]           desc_base_i,
  input  logic [31:0]           desc_count_i,
  input  logic                  desc_valid_i,
  output logic                  desc_ready_o,
  input  logic [DBaseWidth-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic                  mismatch_o,
  output logic [CntWidth-1:0]   checked_count_o,
  output logic [CntWidth-1:0]   error_count_o,
  output logic [31:0]           first_err_addr_o,
  output logic                  first_err_valid_o,
  output logic                  unexpected_o,
  output logic                  timeout_o,
  output logic                  idle_o
);

  localparam int unsigned TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  logic [1:0]      state_q, state_d;
  logic [31:0]     addr_q, addr_d, expect_q, expect_d, remain_q, remain_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            fifo_valid, fifo_pop;
  logic [DESC_ENTRY_W-1:0] fifo_data;
  desc_t           head;

  logic            ev_match_q, ev_match_d, ev_cmp_err_q, ev_cmp_err_d;
  logic            ev_unexp_q, ev_unexp_d, ev_tmo_q, ev_tmo_d;
  logic [31:0]     ev_addr_q, ev_addr_d;

  logic [CntWidth-1:0] checked_q, errors_q;
  logic [31:0]         first_err_addr_q;
  logic                first_err_valid_q, mismatch_q, unexpected_q, timeout_q;

  th_desc_fifo #(
    .Depth (DescDepth),
    .Width (DESC_ENTRY_W)
  ) u_desc_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_valid_i (desc_valid_i),
    .push_data_i  ({desc_addr_i, desc_base_i, desc_count_i}),
    .push_ready_o (desc_ready_o),
    .pop_ready_i  (fifo_pop),
    .pop_valid_o  (fifo_valid),
    .pop_data_o   (fifo_data)
  );

  assign head = desc_t'(fifo_data);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    expect_d     = expect_q;
    remain_d     = remain_q;
    tmo_d        = tmo_q;
    fifo_pop     = 1'b0;
    ev_match_d   = 1'b0;
    ev_cmp_err_d = 1'b0;
    ev_unexp_d   = 1'b0;
    ev_tmo_d     = 1'b0;
    ev_addr_d    = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        ev_unexp_d = data_valid_i;
        if (fifo_valid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ev_unexp_d = data_valid_i;
        fifo_pop   = 1'b1;
        addr_d     = head.addr;
        expect_d   = head.base;
        remain_d   = head.count;
        tmo_d      = '0;
        state_d    = (head.count == '0) ? ST_IDLE : ST_CHECK;
      end
      ST_CHECK: begin
        if (data_valid_i) begin
          tmo_d = '0;
          if (data_i == DBaseWidth'(expect_q)) ev_match_d = 1'b1;
          else                                 ev_cmp_err_d = 1'b1;
          expect_d = expect_q + 32'd1;
          addr_d   = addr_q + 32'd1;
          remain_d = remain_q - 32'd1;
          if (remain_q == 32'd1) state_d = ST_IDLE;
        end else if (tmo_q == TmoLast) begin
          ev_tmo_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      expect_q     <= '0;
      remain_q     <= '0;
      tmo_q        <= '0;
      ev_match_q   <= 1'b0;
      ev_cmp_err_q <= 1'b0;
      ev_unexp_q   <= 1'b0;
      ev_tmo_q     <= 1'b0;
      ev_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      expect_q     <= expect_d;
      remain_q     <= remain_d;
      tmo_q        <= tmo_d;
      ev_match_q   <= ev_match_d;
      ev_cmp_err_q <= ev_cmp_err_d;
      ev_unexp_q   <= ev_unexp_d;
      ev_tmo_q     <= ev_tmo_d;
      ev_addr_q    <= ev_addr_d;
    end
  end

  // Second stage: status is updated one edge after the word is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      checked_q         <= '0;
      errors_q          <= '0;
      first_err_addr_q  <= '0;
      first_err_valid_q <= 1'b0;
      mismatch_q        <= 1'b0;
      unexpected_q      <= 1'b0;
      timeout_q         <= 1'b0;
    end else begin
      mismatch_q <= ev_cmp_err_q || ev_unexp_q;
      if (ev_match_q && (checked_q != '1)) checked_q <= checked_q + 1'b1;
      if ((ev_cmp_err_q || ev_unexp_q || ev_tmo_q) && (errors_q != '1)) begin
        errors_q <= errors_q + 1'b1;
      end
      if (ev_cmp_err_q && !first_err_valid_q) begin
        first_err_addr_q  <= ev_addr_q;
        first_err_valid_q <= 1'b1;
      end
      if (ev_unexp_q) unexpected_q <= 1'b1;
      if (ev_tmo_q)   timeout_q    <= 1'b1;
    end
  end

  assign data_ready_o      = 1'b1;
  assign mismatch_o        = mismatch_q;
  assign checked_count_o   = checked_q;
  assign error_count_o     = errors_q;
  assign first_err_addr_o  = first_err_addr_q;
  assign first_err_valid_o = first_err_valid_q;
  assign unexpected_o      = unexpected_q;
  assign timeout_o         = timeout_q;
  assign idle_o            = (state_q == ST_IDLE) && !fifo_valid;

endmodule

`default_nettype wire

// File: tb/tb_th_response_checker.sv
// tb_th_response_checker: directed stimulus with a per-word scoreboard for th_response_checker.
// Rev 1.0
`default_nettype none

module tb_th_response_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] desc_addr, desc_base, desc_count;
  logic        desc_valid, desc_ready;
  logic [63:0] data;
  logic        data_valid, data_ready;
  logic        mismatch, first_err_valid, unexpected, timeout, idle;
  logic [31:0] checked_count, error_count, first_err_addr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          mm;
    int unsigned chk;
    int unsigned err;
  } exp_t;

  exp_t        sb[$];
  int unsigned exp_chk, exp_err;
  logic        acc_d1, acc_d2;

  always #5 clk = ~clk;

  th_response_checker #(
    .DBaseWidth    (64),
    .DescDepth     (8),
    .CntWidth      (32),
    .TimeoutCycles (16)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .desc_addr_i       (desc_addr),
    .desc_base_i       (desc_base),
    .desc_count_i      (desc_count),
    .desc_valid_i      (desc_valid),
    .desc_ready_o      (desc_ready),
    .data_i            (data),
    .data_valid_i      (data_valid),
    .data_ready_o      (data_ready),
    .mismatch_o        (mismatch),
    .checked_count_o   (checked_count),
    .error_count_o     (error_count),
    .first_err_addr_o  (first_err_addr),
    .first_err_valid_o (first_err_valid),
    .unexpected_o      (unexpected),
    .timeout_o         (timeout),
    .idle_o            (idle)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A word driven before edge E shows its result after edge E+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_d1 <= 1'b0;
      acc_d2 <= 1'b0;
    end else begin
      acc_d1 <= data_valid;
      acc_d2 <= acc_d1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && acc_d2) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("word_mismatch", {63'd0, mismatch}, {63'd0, e.mm});
        check("word_checked", {32'd0, checked_count}, {32'd0, e.chk});
        check("word_errors", {32'd0, error_count}, {32'd0, e.err});
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_desc(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    int t;
    desc_addr  = a;
    desc_base  = b;
    desc_count = c;
    desc_valid = 1'b1;
    t = 0;
    while (!desc_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("desc_accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic word(input logic [63:0] d, input bit mm);
    exp_t e;
    if (mm) exp_err++;
    else    exp_chk++;
    e.mm  = mm;
    e.chk = exp_chk;
    e.err = exp_err;
    sb.push_back(e);
    data       = d;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    desc_valid = 1'b0;
    data_valid = 1'b0;
    sb.delete();
    exp_chk = 0;
    exp_err = 0;
    gap(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; desc_valid = 1'b0; data_valid = 1'b0;
    desc_addr = '0; desc_base = '0; desc_count = '0; data = '0;
    exp_chk = 0; exp_err = 0;
    gap(2);
    check("rst_idle", {63'd0, idle}, 64'd1);
    check("rst_desc_ready", {63'd0, desc_ready}, 64'd1);
    check("rst_data_ready", {63'd0, data_ready}, 64'd1);
    check("rst_checked", {32'd0, checked_count}, 64'd0);
    check("rst_errors", {32'd0, error_count}, 64'd0);
    check("rst_flags", {59'd0, mismatch, first_err_valid, unexpected, timeout, 1'b0}, 64'd0);
    check("rst_first_addr", {32'd0, first_err_addr}, 64'd0);
    rst_n = 1'b1;

    // Clean descriptor, back-to-back words
    push_desc(32'h38c, 32'h0, 32'd4);
    gap(2);
    for (int i = 0; i < 4; i++) word(64'(i), 1'b0);
    gap(3);
    check("t1_checked", {32'd0, checked_count}, 64'd4);
    check("t1_errors", {32'd0, error_count}, 64'd0);
    check("t1_idle", {63'd0, idle}, 64'd1);
    check("t1_first_valid", {63'd0, first_err_valid}, 64'd0);

    // Mismatch in the middle word, first-error address is sticky
    do_reset();
    push_desc(32'h300, 32'hff, 32'd3);
    gap(2);
    word(64'hff, 1'b0);
    word(64'h1ff, 1'b1);
    word(64'h101, 1'b0);
    gap(3);
    check("t2_checked", {32'd0, checked_count}, 64'd2);
    check("t2_errors", {32'd0, error_count}, 64'd1);
    check("t2_first_addr", {32'd0, first_err_addr}, 64'h301);
    check("t2_first_valid", {63'd0, first_err_valid}, 64'd1);
    push_desc(32'h400, 32'h0, 32'd1);
    gap(2);
    word(64'h5, 1'b1);
    gap(3);
    check("t2_errors2", {32'd0, error_count}, 64'd2);
    check("t2_first_addr_kept", {32'd0, first_err_addr}, 64'h301);

    // Word with no descriptor pending
    do_reset();
    word(64'h55, 1'b1);
    gap(3);
    check("t3_unexpected", {63'd0, unexpected}, 64'd1);
    check("t3_errors", {32'd0, error_count}, 64'd1);
    check("t3_checked", {32'd0, checked_count}, 64'd0);
    check("t3_first_valid", {63'd0, first_err_valid}, 64'd0);
    push_desc(32'h0, 32'h0, 32'd1);
    gap(2);
    word(64'h0, 1'b0);
    gap(3);
    check("t3_checked2", {32'd0, checked_count}, 64'd1);

    // Fill the FIFO: one descriptor sits in CHECK, eight more fill the queue
    do_reset();
    for (int k = 0; k < 9; k++) begin
      push_desc(32'h900 + 32'(k), 32'h20 + 32'(k), 32'd1);
      if (k == 7) check("t4_ready_after8", {63'd0, desc_ready}, 64'd1);
    end
    check("t4_full", {63'd0, desc_ready}, 64'd0);
    desc_addr = 32'hdead; desc_base = 32'h99; desc_count = 32'd1; desc_valid = 1'b1;
    gap(2);
    check("t4_still_full", {63'd0, desc_ready}, 64'd0);
    desc_valid = 1'b0;
    word(64'h20, 1'b0);
    for (int k = 1; k < 9; k++) begin
      gap(2);
      word(64'h20 + 64'(k), 1'b0);
    end
    gap(3);
    check("t4_checked", {32'd0, checked_count}, 64'd9);
    check("t4_errors", {32'd0, error_count}, 64'd0);
    push_desc(32'ha00, 32'h0, 32'd0);
    push_desc(32'ha01, 32'h0, 32'd0);
    gap(4);
    check("t4_zero_drain_idle", {63'd0, idle}, 64'd1);
    word(64'h77, 1'b1);
    gap(3);
    check("t4_unexpected", {63'd0, unexpected}, 64'd1);
    check("t4_checked_final", {32'd0, checked_count}, 64'd9);

    // Stall mid-descriptor until the abort
    do_reset();
    push_desc(32'h500, 32'h10, 32'd5);
    gap(2);
    word(64'h10, 1'b0);
    word(64'h11, 1'b0);
    gap(16);
    check("t5_timeout_not_yet", {63'd0, timeout}, 64'd0);
    gap(1);
    exp_err++;
    check("t5_timeout", {63'd0, timeout}, 64'd1);
    check("t5_errors", {32'd0, error_count}, 64'd1);
    check("t5_checked", {32'd0, checked_count}, 64'd2);
    check("t5_idle", {63'd0, idle}, 64'd1);
    push_desc(32'h600, 32'h7, 32'd1);
    gap(2);
    word(64'h7, 1'b0);
    gap(3);
    check("t5_checked2", {32'd0, checked_count}, 64'd3);
    check("t5_errors2", {32'd0, error_count}, 64'd1);

    // 32-bit wrap of the expected value, then async reset mid-descriptor
    do_reset();
    push_desc(32'h700, 32'hffff_ffff, 32'd2);
    gap(2);
    word(64'h0000_0000_ffff_ffff, 1'b0);
    word(64'h0, 1'b0);
    gap(3);
    check("t6_wrap_checked", {32'd0, checked_count}, 64'd2);
    check("t6_wrap_errors", {32'd0, error_count}, 64'd0);
    push_desc(32'h800, 32'h0, 32'd3);
    gap(2);
    word(64'h0, 1'b0);
    gap(2);
    check("t6_busy", {63'd0, idle}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_checked", {32'd0, checked_count}, 64'd0);
    check("t6_async_errors", {32'd0, error_count}, 64'd0);
    check("t6_async_idle", {63'd0, idle}, 64'd1);
    sb.delete();
    exp_chk = 0;
    exp_err = 0;
    gap(1);
    rst_n = 1'b1;
    gap(1);
    word(64'h1, 1'b1);
    gap(3);
    check("t6_progress_discarded", {63'd0, unexpected}, 64'd1);
    check("t6_errors_after", {32'd0, error_count}, 64'd1);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
